// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
// The master issues operations; the slave (the unit) reports busy/done/result.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       operation;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             illegal;

    modport master (
        output operation, in1, in2, start,
        input  busy, done, result, illegal
    );

    modport slave (
        input  operation, in1, in2, start,
        output busy, done, result, illegal
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit (sign-magnitude core, final sign fix-up).
// Define MULDIV_DIV_EN to build the divider; without it, divide op codes report illegal.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input logic          clock,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_MUL    = 4'd7;
    localparam logic [3:0] OP_MULH   = 4'd9;
    localparam logic [3:0] OP_MULHU  = 4'd10;
    localparam logic [3:0] OP_MULHSU = 4'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd3;

`ifdef MULDIV_DIV_EN
    localparam logic [3:0]    OP_DIV   = 4'd12;
    localparam logic [3:0]    OP_DIVU  = 4'd13;
    localparam logic [3:0]    OP_REM   = 4'd14;
    localparam logic [3:0]    OP_REMU  = 4'd15;
    localparam logic [1:0]    ST_DIV   = 2'd2;
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`endif

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [3:0]         op_q;
    logic               neg_main;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier;
    logic               busy_q;
    logic               done_q;
    logic               illegal_q;
    logic [WIDTH-1:0]   result_q;

`ifdef MULDIV_DIV_EN
    logic               neg_rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
`endif

    logic               op_mul;
    logic               op_div;
    logic               a_signed;
    logic               b_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               fast;
    logic [2*WIDTH-1:0] mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_illegal;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.illegal = illegal_q;

    // Decode the incoming request and reduce operands to magnitudes;
    // MIN maps onto itself, which is exactly its unsigned magnitude.
    always_comb begin
        op_mul   = bus.operation inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
        a_signed = bus.operation inside {OP_MUL, OP_MULH, OP_MULHSU};
        b_signed = bus.operation inside {OP_MUL, OP_MULH};
`ifdef MULDIV_DIV_EN
        op_div   = bus.operation inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        a_signed = a_signed | (bus.operation inside {OP_DIV, OP_REM});
        b_signed = b_signed | (bus.operation inside {OP_DIV, OP_REM});
`else
        op_div   = 1'b0;
`endif
        a_neg = a_signed & bus.in1[WIDTH-1];
        b_neg = b_signed & bus.in2[WIDTH-1];
        a_mag = a_neg ? -bus.in1 : bus.in1;
        b_mag = b_neg ? -bus.in2 : bus.in2;
        fast  = !(op_mul | op_div) | (op_mul & ((bus.in1 == '0) | (bus.in2 == '0)));
`ifdef MULDIV_DIV_EN
        fast  = fast | (op_div & ((bus.in2 == '0) |
                ((bus.operation inside {OP_DIV, OP_REM}) &
                 (bus.in1 == MIN_VAL) & (bus.in2 == '1))));
`endif
    end

    always_comb begin
        mul_sum = acc;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (mplier[k]) begin
                mul_sum = mul_sum + (mcand_sh << k);
            end
        end
    end

`ifdef MULDIV_DIV_EN
    // One restoring step: the partial remainder never exceeds the divisor,
    // so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, divisor};
        div_ge    = !div_diff[WIDTH];
    end
`endif

    always_comb begin
        prod        = neg_main ? -acc : acc;
        fix_result  = '0;
        fix_illegal = 1'b0;
        case (op_q)
            OP_MUL:                      fix_result = prod[WIDTH-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU: fix_result = prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:             fix_result = neg_main ? -quo : quo;
            OP_REM, OP_REMU:             fix_result = neg_rem ? -rem : rem;
`endif
            default:                     fix_illegal = 1'b1;
        endcase
    end

    // Fast-path cases preload the datapath registers with their final value
    // and go straight to FIX with the sign flags cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            neg_main  <= 1'b0;
            acc       <= '0;
            mcand_sh  <= '0;
            mplier    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
`ifdef MULDIV_DIV_EN
            neg_rem   <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q   <= 1'b1;
                        op_q     <= bus.operation;
                        cnt      <= '0;
                        neg_main <= fast ? 1'b0 : (a_neg ^ b_neg);
                        acc      <= '0;
                        mcand_sh <= {{WIDTH{1'b0}}, a_mag};
                        mplier   <= b_mag;
`ifdef MULDIV_DIV_EN
                        neg_rem  <= fast ? 1'b0 : a_neg;
                        divisor  <= b_mag;
                        if (op_div && bus.in2 == '0) begin
                            quo <= '1;
                            rem <= bus.in1;
                        end else if (op_div && fast) begin
                            quo <= MIN_VAL;
                            rem <= '0;
                        end else begin
                            quo <= a_mag;
                            rem <= '0;
                        end
`endif
                        if (fast) state <= ST_FIX;
`ifdef MULDIV_DIV_EN
                        else if (op_div) state <= ST_DIV;
`endif
                        else state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc      <= mul_sum;
                    mcand_sh <= mcand_sh << MUL_STEP;
                    mplier   <= mplier >> MUL_STEP;
                    cnt      <= cnt + CW'(1);
                    if (cnt == MUL_LAST) state <= ST_FIX;
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    quo <= {quo[WIDTH-2:0], div_ge};
                    rem <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    cnt <= cnt + CW'(1);
                    if (cnt == DIV_LAST) state <= ST_FIX;
                end
`endif
                ST_FIX: begin
                    result_q  <= fix_result;
                    illegal_q <= fix_illegal;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model; follows MULDIV_DIV_EN like the DUT.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [3:0] legal_ops [8] = '{4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .MUL_STEP(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic bit model_illegal(input logic [3:0] op);
`ifdef MULDIV_DIV_EN
        return !(op inside {4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15});
`else
        return !(op inside {4'd7, 4'd9, 4'd10, 4'd11});
`endif
    endfunction

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0]        sa, sb, za, zb, p;
        logic signed [31:0] as32, bs32;
        logic               ovf;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        za   = {32'd0, a};
        zb   = {32'd0, b};
        as32 = a;
        bs32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        model_result = '0;
        if (model_illegal(op)) return '0;
        case (op)
            4'd7:  begin p = sa * sb; model_result = p[31:0];  end
            4'd9:  begin p = sa * sb; model_result = p[63:32]; end
            4'd10: begin p = za * zb; model_result = p[63:32]; end
            4'd11: begin p = sa * zb; model_result = p[63:32]; end
            4'd12: model_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : as32 / bs32;
            4'd13: model_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: model_result = (b == 0) ? a : ovf ? 32'd0 : as32 % bs32;
            4'd15: model_result = (b == 0) ? a : a % b;
            default: model_result = '0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        if (model_illegal(op)) return 1;
        if (op inside {4'd7, 4'd9, 4'd10, 4'd11}) return (a == 0 || b == 0) ? 1 : 9;
        if (b == 0) return 1;
        if ((op inside {4'd12, 4'd14}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.operation = op;
        bus.in1       = a;
        bus.in2       = b;
        bus.start     = 1'b1;
    endtask

    // Lets E0 happen, scrambles the inputs, then reports where done appeared.
    task automatic wait_done(output int lat, output logic [31:0] res, output logic ill,
                             output logic busy_e0, output logic busy_done);
        lat       = -1;
        res       = '0;
        ill       = 1'b0;
        busy_done = 1'b1;
        @(posedge clock);
        #1;
        bus.start     = 1'b0;
        bus.in1       = $urandom;
        bus.in2       = $urandom;
        bus.operation = 4'($urandom);
        busy_e0       = bus.busy;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat       = n;
                res       = bus.result;
                ill       = bus.illegal;
                busy_done = bus.busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.operation = '0;
        bus.in1       = '0;
        bus.in2       = '0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.illegal} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.illegal});
        end
        total++;
        if (bus.result !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_result: got %h expected 00000000", bus.result);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_mul_directed();
        logic [3:0]  ops  [6] = '{4'd7, 4'd9, 4'd10, 4'd11, 4'd7, 4'd9};
        logic [31:0] as   [6] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd12345, 32'h8000_0000};
        logic [31:0] exps [6] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'd0, 32'h4000_0000};
        int          lats [6] = '{9, 9, 9, 9, 1, 9};
        logic [31:0] res;
        logic        ill, be0, bd;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            drive_start(ops[i], as[i], bs[i]);
            wait_done(lat, res, ill, be0, bd);
            total++;
            if (res !== exps[i] || ill !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mul_dir_%0d: got %h ill=%b expected %h ill=0", i, res, ill, exps[i]);
            end
            total++;
            if (lat != lats[i] || be0 !== 1'b1 || bd !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mul_dir_lat_%0d: got E%0d busy=%b/%b expected E%0d busy=1/0",
                         i, lat, be0, bd, lats[i]);
            end
        end
        @(posedge clock);
        #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_strobe: got %b expected 0", bus.done);
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div_directed();
        logic [3:0]  ops  [9] = '{4'd12, 4'd14, 4'd13, 4'd15, 4'd13, 4'd15, 4'd12, 4'd14, 4'd14};
        logic [31:0] as   [9] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                  32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] bs   [9] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exps [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                                  32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9};
        int          lats [9] = '{33, 33, 33, 33, 1, 1, 1, 1, 1};
        logic [31:0] res;
        logic        ill, be0, bd;
        int          lat;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            drive_start(ops[i], as[i], bs[i]);
            wait_done(lat, res, ill, be0, bd);
            total++;
            if (res !== exps[i] || ill !== 1'b0) begin
                bad++;
                $display("[TB] FAIL div_dir_%0d: got %h ill=%b expected %h ill=0", i, res, ill, exps[i]);
            end
            total++;
            if (lat != lats[i] || be0 !== 1'b1 || bd !== 1'b0) begin
                bad++;
                $display("[TB] FAIL div_dir_lat_%0d: got E%0d busy=%b/%b expected E%0d busy=1/0",
                         i, lat, be0, bd, lats[i]);
            end
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [31:0] res;
        logic        ill, be0, bd;
        int          lat;
        for (int op = 12; op <= 15; op++) begin
            @(negedge clock);
            drive_start(4'(op), 32'd100, 32'd7);
            wait_done(lat, res, ill, be0, bd);
            total++;
            if (res !== 32'd0 || ill !== 1'b1 || lat != 1) begin
                bad++;
                $display("[TB] FAIL div_off_%0d: got %h ill=%b E%0d expected 00000000 ill=1 E1",
                         op, res, ill, lat);
            end
        end
    endtask
`endif

    task automatic test_illegal();
        logic [3:0]  ops [3] = '{4'd3, 4'd0, 4'd8};
        logic [31:0] res;
        logic        ill, be0, bd;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive_start(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            wait_done(lat, res, ill, be0, bd);
            @(negedge clock);
            drive_start(ops[i], 32'h1234_5678, 32'h9ABC_DEF0);
            wait_done(lat, res, ill, be0, bd);
            total++;
            if (res !== 32'd0 || ill !== 1'b1 || lat != 1) begin
                bad++;
                $display("[TB] FAIL illegal_%0d: got %h ill=%b E%0d expected 00000000 ill=1 E1",
                         ops[i], res, ill, lat);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int          lat = -1;
        int          dones = 0;
        logic [31:0] res = '0;
        logic        busy_mid = 1'b0;
        @(negedge clock);
        drive_start(4'd7, 32'd7, 32'd6);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    res = bus.result;
                end
            end
            if (n == 2) drive_start(4'd10, 32'd100, 32'd100);
            if (n == 3) begin
                bus.start = 1'b0;
                busy_mid  = bus.busy;
            end
        end
        total++;
        if (res !== 32'd42 || lat != 9 || dones != 1) begin
            bad++;
            $display("[TB] FAIL busy_ignore: got %h E%0d dones=%0d expected 0000002a E9 dones=1",
                     res, lat, dones);
        end
        total++;
        if (busy_mid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_mid: got %b expected 1", busy_mid);
        end
    endtask

    task automatic test_reset_abort();
        bit seen = 1'b0;
        @(negedge clock);
        drive_start(4'd7, 32'h0001_2345, 32'h0000_0777);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        drive_start(4'd9, 32'd3, 32'd5);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        reset = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.illegal} !== 3'b000 || bus.result !== 32'd0) begin
            bad++;
            $display("[TB] FAIL abort_clear: got flags=%b result=%h expected 000 00000000",
                     {bus.busy, bus.done, bus.illegal}, bus.result);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL abort_no_done: got activity=1 expected 0");
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        ill, be0, bd;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = (i % 10 == 9) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 7)];
            a  = rand_operand();
            b  = rand_operand();
            @(negedge clock);
            drive_start(op, a, b);
            wait_done(lat, res, ill, be0, bd);
            total++;
            if (res !== model_result(op, a, b) || ill !== model_illegal(op)) begin
                bad++;
                $display("[TB] FAIL rand_%0d op=%0d a=%h b=%h: got %h ill=%b expected %h ill=%b",
                         i, op, a, b, res, ill, model_result(op, a, b), model_illegal(op));
            end
            total++;
            if (lat != model_latency(op, a, b) || be0 !== 1'b1 || bd !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rand_lat_%0d op=%0d: got E%0d busy=%b/%b expected E%0d busy=1/0",
                         i, op, lat, be0, bd, model_latency(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        ill, be0, bd;
        int          lat;
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            op = legal_ops[$urandom_range(0, 7)];
            a  = rand_operand();
            b  = rand_operand();
            drive_start(op, a, b);
            wait_done(lat, res, ill, be0, bd);
            total++;
            if (res !== model_result(op, a, b) || lat != model_latency(op, a, b) || be0 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_%0d op=%0d: got %h E%0d busy=%b expected %h E%0d busy=1",
                         i, op, res, lat, be0, model_result(op, a, b), model_latency(op, a, b));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul_directed();
`ifdef MULDIV_DIV_EN
        test_div_directed();
`else
        test_div_disabled();
`endif
        test_illegal();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
